midi_voice_alloc: RTL

MIDI_VOICE_ALLOC -- requirements
Module: midi_voice_alloc

---
 rtl/midi_voice_alloc.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/midi_voice_alloc.sv
// rtl/midi_voice_alloc.sv - MIDI note-on/off parser with LRU polyphonic voice allocator
// Define VOICE_STEAL_EN to let a note-on steal the oldest voice when every voice is gated.
module midi_voice_alloc #(
  parameter int VOICES       = 4,
  parameter int MIDI_CHANNEL = 0
) (
  input  logic                         clk_i,
  input  logic                         nrst_i,
  input  logic [7:0]                   midiByte_i,
  input  logic                         midiByteValid_i,
  output logic [7*VOICES-1:0]          voiceNote_o,
  output logic [VOICES-1:0]            voiceGate_o,
  output logic                         noteOnStrb_o,
  output logic                         noteOffStrb_o,
  output logic [$clog2(VOICES+1)-1:0]  activeCount_o
);

  localparam int IW = $clog2(VOICES);
  localparam int CW = $clog2(VOICES+1);

  typedef enum logic [1:0] {IDLE, DATA1, DATA2, SKIP} state_t;

  state_t         state, state_nxt;
  logic           rs_valid, rs_valid_nxt;
  logic           rs_on, rs_on_nxt;
  logic           latch_note, msg_done;
  logic [6:0]     note_q;
  logic [6:0]     voice_note [VOICES];
  logic [VOICES-1:0] gate;
  // age rank per voice: 0 is the oldest, VOICES-1 the most recently used
  logic [IW-1:0]  age [VOICES];

  logic           is_rt, is_sys, is_own;
  logic           is_on;
  logic           hit, free_any;
  logic [IW-1:0]  hit_idx, free_idx, old_idx;
  logic           alloc_en, touch_en, rel_en, on_pulse, off_pulse;
  logic [IW-1:0]  alloc_idx, touch_idx;

  assign is_rt  = midiByte_i[7:3] == 5'b11111;
  assign is_sys = midiByte_i[7:3] == 5'b11110;
  assign is_own = (midiByte_i[7:4] == 4'h8 || midiByte_i[7:4] == 4'h9) &&
                  midiByte_i[3:0] == 4'(MIDI_CHANNEL);
  assign is_on  = rs_on && (midiByte_i[6:0] != 7'd0);

  always_comb begin
    state_nxt    = state;
    rs_valid_nxt = rs_valid;
    rs_on_nxt    = rs_on;
    latch_note   = 1'b0;
    msg_done     = 1'b0;
    if (midiByteValid_i && !is_rt) begin
      if (is_sys) begin
        state_nxt    = IDLE;
        rs_valid_nxt = 1'b0;
      end else if (midiByte_i[7]) begin
        if (is_own) begin
          state_nxt    = DATA1;
          rs_valid_nxt = 1'b1;
          rs_on_nxt    = midiByte_i[4];
        end else begin
          state_nxt    = SKIP;
          rs_valid_nxt = 1'b0;
        end
      end else if (rs_valid) begin
        case (state)
          DATA1: begin
            latch_note = 1'b1;
            state_nxt  = DATA2;
          end
          DATA2: begin
            msg_done  = 1'b1;
            state_nxt = DATA1;
          end
          default: ;
        endcase
      end
    end
  end

  // Descending scan so the lowest matching index wins
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    old_idx  = '0;
    for (int v = VOICES-1; v >= 0; v--) begin
      if (gate[v] && voice_note[v] == note_q) begin
        hit     = 1'b1;
        hit_idx = IW'(v);
      end
      if (!gate[v]) begin
        free_any = 1'b1;
        free_idx = IW'(v);
      end
      if (age[v] == '0) old_idx = IW'(v);
    end
  end

  always_comb begin
    alloc_en  = 1'b0;
    alloc_idx = '0;
    touch_en  = 1'b0;
    touch_idx = '0;
    rel_en    = 1'b0;
    on_pulse  = 1'b0;
    off_pulse = 1'b0;
    if (msg_done) begin
      if (is_on) begin
        if (hit) begin
          touch_en  = 1'b1;
          touch_idx = hit_idx;
          on_pulse  = 1'b1;
        end else if (free_any) begin
          alloc_en  = 1'b1;
          alloc_idx = free_idx;
          touch_en  = 1'b1;
          touch_idx = free_idx;
          on_pulse  = 1'b1;
        end else begin
`ifdef VOICE_STEAL_EN
          alloc_en  = 1'b1;
          alloc_idx = old_idx;
          touch_en  = 1'b1;
          touch_idx = old_idx;
          on_pulse  = 1'b1;
`else
          on_pulse  = 1'b0;
`endif
        end
      end else begin
        off_pulse = 1'b1;
        rel_en    = hit;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      rs_valid      <= 1'b0;
      rs_on         <= 1'b0;
      note_q        <= '0;
      gate          <= '0;
      noteOnStrb_o  <= 1'b0;
      noteOffStrb_o <= 1'b0;
      for (int v = 0; v < VOICES; v++) begin
        voice_note[v] <= '0;
        age[v]        <= IW'(v);
      end
    end else begin
      rs_valid      <= rs_valid_nxt;
      rs_on         <= rs_on_nxt;
      noteOnStrb_o  <= on_pulse;
      noteOffStrb_o <= off_pulse;
      if (latch_note) note_q <= midiByte_i[6:0];
      if (alloc_en) begin
        voice_note[alloc_idx] <= note_q;
        gate[alloc_idx]       <= 1'b1;
      end
      if (rel_en) gate[hit_idx] <= 1'b0;
      if (touch_en) begin
        for (int v = 0; v < VOICES; v++) begin
          if (IW'(v) == touch_idx) age[v] <= IW'(VOICES-1);
          else if (age[v] > age[touch_idx]) age[v] <= age[v] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    activeCount_o = '0;
    for (int v = 0; v < VOICES; v++) activeCount_o = activeCount_o + CW'(gate[v]);
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_note
    assign voiceNote_o[7*g +: 7] = voice_note[g];
  end
  assign voiceGate_o = gate;

endmodule
